wb_except_ctrl: RTL
===================

// Module: wb_except_ctrl
// PURPOSE
// - Writeback-stage exception/ERTN arbiter: prioritises exception flags carried by the retiring WB instruction plus pending interrupts.
// - Produces the wb_ex/wb_ecode/wb_esubcode/wb_pc/eret_flush event consumed by the CSR file, and the commit enable for RF write-back.
// - Runs a flush handshake to fetch with redirect target EENTRY (exception) or ERA (ertn), cancelling WB retirement until fetch accepts.
// PARAMETERS
// - PC_W       32  PC / address width
// - NUM_EXSRC   5  per-instruction exception flags {ALE,BRK,SYS,INE,ADEF} (bit4..bit0)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - ws_valid     in   1      WB holds a valid instruction this cycle
// - ws_pc        in   PC_W   PC of WB instruction
// - ws_ex_flags  in   5      {ALE,BRK,SYS,INE,ADEF} raised upstream for this instruction
// - ws_vaddr     in   PC_W   data address (meaningful with ALE)
// - ws_ertn      in   1      WB instruction is ertn
// - int_pending  in   1      |(ESTAT.IS & ECFG.LIE) & CRMD.IE, from CSR file
// - csr_eentry   in   PC_W   EENTRY read value
// - csr_era      in   PC_W   ERA read value
// - ws_commit_en out  1      WB instruction retires normally (RF/CSR write allowed)
// - wb_ex        out  1      exception taken this cycle (1-cycle pulse)
// - wb_ecode     out  6      Ecode of taken exception
// - wb_esubcode  out  9      EsubCode of taken exception
// - wb_pc        out  PC_W   PC recorded into ERA
// - wb_vaddr     out  PC_W   faulting address (BADV)
// - eret_flush   out  1      ertn retires this cycle (1-cycle pulse)
// - pipe_flush   out  1      1-cycle pulse clearing IF..MEM stage valids
// - flush_req    out  1      redirect request to fetch
// - flush_pc     out  PC_W   redirect target, stable while flush_req
// - flush_ack    in   1      fetch accepts redirect
// BEHAVIOUR
// - FSM: IDLE, FLUSH. Reset -> IDLE; all outputs 0, int_q=0, target reg=0.
// - int_q <= int_pending every cycle (1-cycle sample, breaks CSR comb path).
// - live = ws_valid & (state==IDLE). All event outputs are comb, gated by live.
// - Priority on live: INT(int_q) > ADEF > INE > SYS > BRK > ALE.
//   Ecode: INT 0x00, ADE 0x08/sub ADEF 0, INE 0x0D, SYS 0x0B, BRK 0x0C, ALE 0x09; esubcode 0 for all.
// - ex_hit = live & (int_q | |ws_ex_flags): wb_ex=1, wb_pc=ws_pc, ws_commit_en=0.
//   wb_vaddr = ws_pc for ADEF, ws_vaddr for ALE, else 0.
// - Exception present -> ws_ertn ignored (eret_flush=0).
// - live & ~ex_hit & ws_ertn: eret_flush=1, ws_commit_en=1.
// - live & neither: ws_commit_en=1, no flush.
// - On wb_ex or eret_flush: pipe_flush=1 same cycle; target <= csr_eentry (ex) or csr_era (ertn), sampled pre-update; next state FLUSH.
// - FLUSH: flush_req=1, flush_pc=target; ws_commit_en/wb_ex/eret_flush forced 0 (wrong-path WB work dropped).
//   flush_ack=1 -> IDLE next cycle; otherwise hold and keep target unchanged.
// - flush_ack while IDLE: ignored. int_q rising during FLUSH: held in int_q, taken on first live instruction after IDLE.
// - Interrupt tags a live instruction, which does not execute; ERA = its PC.
// - Reset mid-FLUSH: IDLE next cycle, flush_req drops, no event emitted.
// - Latency: event-to-flush_req = 1 cycle; min event-to-event spacing = 2 cycles (ack on first FLUSH cycle).
// STRUCTURE
// - mycpu.h: ECODE_INT/ADE/ALE/SYS/BRK/INE, ESUBCODE_ADEF, WB_EXFLAG_* bit indices, FSM state encodings.
// - Sub-module ex_prio_enc: comb priority encoder, {int_q, flags} -> {hit, ecode, esubcode, is_adef, is_ale}.
// - Top level: FSM, int_q, target register, output gating.
// TESTING
// - SYS at pc 0x1c000100, eentry 0x1c008000: wb_ex=1, ecode 0x0B, wb_pc 0x1c000100, pipe_flush=1; next cycle flush_req=1, flush_pc 0x1c008000.
// - ADEF+INE together, pc 0x1c000003: ecode 0x08, esubcode 0, wb_vaddr 0x1c000003; INE not reported.
// - ertn, era 0x1c000200: eret_flush=1, wb_ex=0; hold flush_ack=0 for 3 cycles -> flush_pc stable 0x1c000200, then IDLE 1 cycle after ack.
// - FLUSH with ws_valid=1 plus BRK flag: wb_ex=0, ws_commit_en=0; event dropped.
// - int_pending at cycle N, valid ALE instr at N+1: ecode 0x00 (INT beats ALE), wb_pc = instr PC.
// - reset during FLUSH with flush_ack=0: next cycle flush_req=0; next ws_valid instr commits (ws_commit_en=1).

Source files
------------

// File: rtl/wb_except_ctrl_pkg.sv
// Shared constants for the writeback exception/ERTN arbiter: exception codes,
// per-instruction flag bit positions and flush FSM state encodings.
package wb_except_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

    localparam int unsigned WB_EXFLAG_ADEF = 0;
    localparam int unsigned WB_EXFLAG_INE  = 1;
    localparam int unsigned WB_EXFLAG_SYS  = 2;
    localparam int unsigned WB_EXFLAG_BRK  = 3;
    localparam int unsigned WB_EXFLAG_ALE  = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        logic       hit;
        logic [5:0] ecode;
        logic [8:0] esubcode;
        logic       is_adef;
        logic       is_ale;
    } ex_sel_t;

endpackage

// File: rtl/wb_except_ctrl_ex_prio_enc.sv
// Combinational priority encoder selecting the single exception reported for
// the retiring instruction: INT > ADEF > INE > SYS > BRK > ALE.
module ex_prio_enc
    import wb_except_ctrl_pkg::*;
(
    input  logic       int_i,
    input  logic [4:0] flags_i,
    output ex_sel_t    sel_o
);

    always_comb begin
        sel_o          = '0;
        sel_o.hit      = int_i | (|flags_i);
        sel_o.esubcode = '0;
        if (int_i) begin
            sel_o.ecode = ECODE_INT;
        end else if (flags_i[WB_EXFLAG_ADEF]) begin
            sel_o.ecode    = ECODE_ADE;
            sel_o.esubcode = ESUBCODE_ADEF;
            sel_o.is_adef  = 1'b1;
        end else if (flags_i[WB_EXFLAG_INE]) begin
            sel_o.ecode = ECODE_INE;
        end else if (flags_i[WB_EXFLAG_SYS]) begin
            sel_o.ecode = ECODE_SYS;
        end else if (flags_i[WB_EXFLAG_BRK]) begin
            sel_o.ecode = ECODE_BRK;
        end else if (flags_i[WB_EXFLAG_ALE]) begin
            sel_o.ecode  = ECODE_ALE;
            sel_o.is_ale = 1'b1;
        end
    end

endmodule

// File: rtl/wb_except_ctrl.sv
// Writeback-stage exception/ERTN arbiter: emits the CSR exception event,
// gates RF commit, and runs the redirect handshake with fetch.
module wb_except_ctrl
    import wb_except_ctrl_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int NUM_EXSRC = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ws_valid,
    input  logic [PC_W-1:0]      ws_pc,
    input  logic [NUM_EXSRC-1:0] ws_ex_flags,
    input  logic [PC_W-1:0]      ws_vaddr,
    input  logic                 ws_ertn,
    input  logic                 int_pending,
    input  logic [PC_W-1:0]      csr_eentry,
    input  logic [PC_W-1:0]      csr_era,
    output logic                 ws_commit_en,
    output logic                 wb_ex,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic [PC_W-1:0]      wb_pc,
    output logic [PC_W-1:0]      wb_vaddr,
    output logic                 eret_flush,
    output logic                 pipe_flush,
    output logic                 flush_req,
    output logic [PC_W-1:0]      flush_pc,
    input  logic                 flush_ack
);

    logic [0:0]      state_q, state_d;
    logic            int_q;
    logic [PC_W-1:0] target_q, target_d;
    logic            live;
    logic            ex_hit;
    ex_sel_t         sel;

    ex_prio_enc u_prio (
        .int_i   (int_q),
        .flags_i (ws_ex_flags),
        .sel_o   (sel)
    );

    assign live   = ws_valid & (state_q == ST_IDLE);
    assign ex_hit = live & sel.hit;

    always_comb begin
        wb_ex        = ex_hit;
        wb_ecode     = ex_hit ? sel.ecode    : '0;
        wb_esubcode  = ex_hit ? sel.esubcode : '0;
        wb_pc        = ex_hit ? ws_pc        : '0;
        wb_vaddr     = '0;
        if (ex_hit && sel.is_adef) begin
            wb_vaddr = ws_pc;
        end else if (ex_hit && sel.is_ale) begin
            wb_vaddr = ws_vaddr;
        end
        // An exception on the same instruction suppresses its ertn.
        eret_flush   = live & ~sel.hit & ws_ertn;
        ws_commit_en = live & ~sel.hit;
        pipe_flush   = wb_ex | eret_flush;
        flush_req    = (state_q == ST_FLUSH);
        flush_pc     = (state_q == ST_FLUSH) ? target_q : '0;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_ex) begin
                    target_d = csr_eentry;
                    state_d  = ST_FLUSH;
                end else if (eret_flush) begin
                    target_d = csr_era;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            int_q    <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            int_q    <= int_pending;
            target_q <= target_d;
        end
    end

endmodule
